// File: rtl/huffman_axil_pkg.sv
// Shared constants and helpers for the four-word AXI4-Lite register block.
package huffman_axil_pkg;

  localparam int NUM_REGS = 4;
  localparam int IDX_W    = 2;

  localparam logic [IDX_W-1:0] REG0_IDX = 2'd0;
  localparam logic [IDX_W-1:0] REG1_IDX = 2'd1;
  localparam logic [IDX_W-1:0] REG2_IDX = 2'd2;
  localparam logic [IDX_W-1:0] REG3_IDX = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/huffman_axil_regs.sv
// AXI4-Lite slave exposing four 32-bit read/write registers with per-register
// write strobes; AW and W are captured independently into one-entry holds.
module huffman_axil_regs
  import huffman_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                                   S_AXI_ACLK,
  input  logic                                   S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]                    reg_wr_pulse
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;

  logic             aw_held_q, aw_held_d;
  logic [IDX_W-1:0] aw_idx_q, aw_idx_d;
  logic             w_held_q, w_held_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [SW-1:0]    wstrb_q, wstrb_d;
  logic             bvalid_q, bvalid_d;
  logic             rvalid_q, rvalid_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [NUM_REGS-1:0] pulse_q, pulse_d;
  logic [DW-1:0]    regs_q [NUM_REGS];
  logic [DW-1:0]    regs_d [NUM_REGS];

  logic aw_fire, w_fire, ar_fire, commit;

  // A transfer happens on the rising edge where VALID and READY are both 1;
  // READY never depends on VALID, and VALID/data stay stable until that edge.
  assign S_AXI_AWREADY = !S_AXI_ARESET && !aw_held_q && !bvalid_q;
  assign S_AXI_WREADY  = !S_AXI_ARESET && !w_held_q  && !bvalid_q;
  assign S_AXI_ARREADY = !S_AXI_ARESET && !rvalid_q;

  assign aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_fire  = S_AXI_WVALID  && S_AXI_WREADY;
  assign ar_fire = S_AXI_ARVALID && S_AXI_ARREADY;
  assign commit  = aw_held_q && w_held_q && !bvalid_q;

  always_comb begin
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    pulse_d   = '0;
    regs_d    = regs_q;

    if (aw_fire) begin
      aw_held_d = 1'b1;
      aw_idx_d  = S_AXI_AWADDR[3:2];
    end
    if (w_fire) begin
      w_held_d = 1'b1;
      wdata_d  = S_AXI_WDATA;
      wstrb_d  = S_AXI_WSTRB;
    end

    // Commit only uses values held at the start of the cycle, so a write
    // always takes one edge after its last handshake.
    if (commit) begin
      regs_d[aw_idx_q]  = merge_bytes(regs_q[aw_idx_q], wdata_q, wstrb_q);
      aw_held_d         = 1'b0;
      w_held_d          = 1'b0;
      bvalid_d          = 1'b1;
      pulse_d[aw_idx_q] = 1'b1;
    end else if (bvalid_q && S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end

    // Reads sample regs_q, so a read on a commit edge sees the old value.
    if (ar_fire) begin
      rvalid_d = 1'b1;
      rdata_d  = regs_q[S_AXI_ARADDR[3:2]];
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      pulse_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      pulse_q   <= pulse_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_q[i*DW +: DW] = regs_q[i];
  end

  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_BRESP  = RESP_OKAY;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RDATA  = rdata_q;
  assign S_AXI_RRESP  = RESP_OKAY;
  assign reg_wr_pulse = pulse_q;

  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_huffman_axil_regs.sv
// Scoreboard bench for huffman_axil_regs: drivers push expected responses,
// a negedge monitor pops and compares whenever the DUT presents an output.
module tb_huffman_axil_regs;
  import huffman_axil_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   awaddr;
  logic [2:0]   awprot;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [3:0]   araddr;
  logic [2:0]   arprot;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic [127:0] reg_q;
  logic [3:0]   reg_wr_pulse;

  huffman_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
  );

  // clock / reset
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_r[$];
  logic [1:0]  exp_b[$];
  logic [3:0]  exp_pulse[$];
  logic [31:0] model [4];

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void model_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] mask;
    mask = 32'h0;
    for (int b = 0; b < 4; b++) if (strb[b]) mask = mask | (32'hFF << (8*b));
    model[addr[3:2]] = (model[addr[3:2]] & ~mask) | (data & mask);
  endfunction

  // monitor / scoreboard
  logic        r_pend = 1'b0;
  logic [31:0] r_prev = '0;

  task automatic monitor_step();
    if (rst) begin
      r_pend = 1'b0;
      return;
    end
    if (r_pend) begin
      check("r_hold_valid", rvalid, 1'b1);
      check("r_hold_data", rdata, r_prev);
    end
    if (rvalid && rready) begin
      if (exp_r.size() == 0) check("r_unexpected", 1'b1, 1'b0);
      else begin
        check("rdata", rdata, exp_r.pop_front());
        check("rresp", rresp, RESP_OKAY);
      end
    end
    if (bvalid && bready) begin
      if (exp_b.size() == 0) check("b_unexpected", 1'b1, 1'b0);
      else check("bresp", bresp, exp_b.pop_front());
    end
    if (reg_wr_pulse != 4'b0) begin
      if (exp_pulse.size() == 0) check("pulse_unexpected", reg_wr_pulse, 4'b0);
      else check("wr_pulse", reg_wr_pulse, exp_pulse.pop_front());
    end
    r_pend = rvalid && !rready;
    r_prev = rdata;
  endtask

  initial forever begin
    @(negedge clk);
    monitor_step();
  end

  // driver tasks
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly);
    bit aw_done = 0;
    bit w_done = 0;
    int cyc = 0;
    model_write(addr, data, strb);
    exp_b.push_back(RESP_OKAY);
    exp_pulse.push_back(4'b0001 << addr[3:2]);
    awaddr = addr;
    wdata  = data;
    wstrb  = strb;
    while (!(aw_done && w_done) && cyc < 50) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done  && (cyc >= w_dly);
      @(negedge clk);
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      @(posedge clk); #1;
      cyc++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    if (!(aw_done && w_done)) begin
      check("write_accept_timeout", {aw_done, w_done}, 2'b11);
      return;
    end
    @(negedge clk);
    check("b_not_before_commit", bvalid, 1'b0);
    @(posedge clk); #1;
    check("b_after_commit", bvalid, 1'b1);
    check("reg_updated", reg_q[addr[3:2]*32 +: 32], model[addr[3:2]]);
    for (int i = 0; i < b_dly; i++) begin
      @(negedge clk);
      check("b_hold", bvalid, 1'b1);
      check("aw_blocked", awready, 1'b0);
      check("w_blocked", wready, 1'b0);
      @(posedge clk); #1;
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read_exp(input logic [3:0] addr, input logic [31:0] exp, input int r_dly);
    bit done = 0;
    int cyc = 0;
    araddr  = addr;
    arvalid = 1'b1;
    while (!done && cyc < 50) begin
      @(negedge clk);
      if (arready) begin
        done = 1;
        exp_r.push_back(exp);
      end
      @(posedge clk); #1;
      cyc++;
    end
    arvalid = 1'b0;
    if (!done) begin
      check("ar_timeout", 1'b0, 1'b1);
      return;
    end
    repeat (r_dly) begin @(posedge clk); #1; end
    rready = 1'b1;
    done = 0;
    cyc = 0;
    while (!done && cyc < 50) begin
      @(negedge clk);
      if (rvalid) done = 1;
      @(posedge clk); #1;
      cyc++;
    end
    rready = 1'b0;
    if (!done) check("r_timeout", 1'b0, 1'b1);
  endtask

  task automatic axi_read(input logic [3:0] addr, input int r_dly);
    axi_read_exp(addr, model[addr[3:2]], r_dly);
  endtask

  task automatic check_reset_outputs();
    check("rst_awready", awready, 1'b0);
    check("rst_wready", wready, 1'b0);
    check("rst_arready", arready, 1'b0);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_resp", {bresp, rresp}, 4'b0);
    check("rst_reg_q", reg_q, 128'h0);
    check("rst_pulse", reg_wr_pulse, 4'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs;
    logic [31:0] d;
    rst = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
    bready = 0; araddr = '0; arprot = '0; arvalid = 0; rready = 0;
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {awready, wready, arready}, 3'b111);
    @(posedge clk); #1;

    // basic write/read-back
    for (int i = 0; i < 4; i++) axi_write(4'(i*4), 32'(i+1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) axi_read_exp(4'(i*4), 32'(i+1), 0);

    // read on the commit edge of a write to the same register
    awaddr = 4'h4; wdata = 32'hAAAA0000; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    exp_b.push_back(RESP_OKAY);
    exp_pulse.push_back(4'b0010);
    @(negedge clk);
    check("same_edge_aw_w_ready", {awready, wready}, 2'b11);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    araddr = 4'h4; arvalid = 1;
    exp_r.push_back(model[1]);
    model_write(4'h4, 32'hAAAA0000, 4'hF);
    @(negedge clk);
    check("commit_edge_arready", arready, 1'b1);
    @(posedge clk); #1;
    arvalid = 0;
    rready = 1; bready = 1;
    hs = 0;
    while ((bvalid || rvalid) && hs < 20) begin @(posedge clk); #1; hs++; end
    check("commit_edge_drain", {bvalid, rvalid}, 2'b00);
    rready = 0; bready = 0;
    axi_read(4'h4, 1);

    // W presented three cycles before AW
    axi_write(4'h8, $urandom, 4'hF, 3, 0, 0);
    axi_read(4'h8, 0);

    // byte-strobe merge
    axi_write(4'h4, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    axi_write(4'h5, 32'h12345678, 4'b0101, 0, 1, 0);
    axi_read_exp(4'h4, 32'hFF34FF78, 2);

    // B back-pressure blocks a second write
    awaddr = 4'hC; wdata = 32'hC0DE0001; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    model_write(4'hC, 32'hC0DE0001, 4'hF);
    exp_b.push_back(RESP_OKAY);
    exp_pulse.push_back(4'b1000);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    @(posedge clk); #1;
    awaddr = 4'h0; wdata = 32'h5A5A5A5A; awvalid = 1; wvalid = 1;
    repeat (5) begin
      @(negedge clk);
      check("bp_bvalid", bvalid, 1'b1);
      check("bp_awready", awready, 1'b0);
      check("bp_wready", wready, 1'b0);
      @(posedge clk); #1;
    end
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    @(negedge clk);
    check("bp_second_accept", {awready, wready}, 2'b11);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    model_write(4'h0, 32'h5A5A5A5A, 4'hF);
    exp_b.push_back(RESP_OKAY);
    exp_pulse.push_back(4'b0001);
    @(posedge clk); #1;
    check("bp_second_bvalid", bvalid, 1'b1);
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    axi_read(4'hC, 0);
    axi_read(4'h0, 0);

    // back-to-back reads with RREADY tied high
    rready = 1; arvalid = 1; araddr = 4'h0; hs = 0;
    for (int c = 0; c < 12; c++) begin
      bit took = 0;
      @(negedge clk);
      if (arready) begin
        exp_r.push_back(model[araddr[3:2]]);
        hs++;
        took = 1;
      end
      @(posedge clk); #1;
      if (took) araddr = 4'($urandom_range(0, 15));
    end
    arvalid = 0;
    repeat (2) begin @(posedge clk); #1; end
    rready = 0;
    check("read_throughput", hs, 6);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1)
        axi_write(4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        axi_read(4'($urandom_range(0, 15)), $urandom_range(0, 3));
    end
    for (int i = 0; i < 4; i++) check("reg_q_model", reg_q[i*32 +: 32], model[i]);

    // reset with W held and a read pending
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1;
    @(negedge clk);
    check("pre_reset_w_accept", wready, 1'b1);
    @(posedge clk); #1;
    wvalid = 0;
    araddr = 4'h4; arvalid = 1;
    @(posedge clk); #1;
    arvalid = 0;
    @(negedge clk);
    check("pre_reset_r_pending", rvalid, 1'b1);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    repeat (2) begin
      @(negedge clk);
      check_reset_outputs();
      @(posedge clk); #1;
    end
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    rst = 0;
    @(negedge clk);
    check("ready_after_mid_reset", {awready, wready, arready}, 3'b111);
    check("no_b_after_reset", bvalid, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) axi_read_exp(4'(i*4), 32'h0, 0);
    d = $urandom;
    axi_write(4'h0, d, 4'hF, 0, 4, 0);
    axi_read(4'h0, 0);

    repeat (3) begin @(posedge clk); #1; end
    check("exp_r_drained", exp_r.size(), 0);
    check("exp_b_drained", exp_b.size(), 0);
    check("exp_pulse_drained", exp_pulse.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
